// File: rtl/division_unit.sv
// division_unit: sequential restoring divider for div/divu.
// Produces one quotient bit per cycle and writes the remainder to HI and the
// quotient to LO once all 32 iterations have completed. A zero divisor
// finishes immediately with div_zero set and HI/LO untouched.
module division_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [1:0]       stateOut
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        DONE   = 2'b10,
        UNUSED = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               signA_q, signA_d;
    logic               signB_q, signB_d;
    logic               zero_q, zero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [WIDTH-1:0]   magA;
    logic [WIDTH-1:0]   magB;
    logic [WIDTH:0]     remShift;
    logic               trialOk;
    logic [WIDTH-1:0]   trial;
    logic [WIDTH-1:0]   remNext;
    logic [WIDTH-1:0]   quoNext;

    // Operand magnitudes; in unsigned mode the raw bits are the magnitude.
    // The most negative value negates to itself, which reads as 2^31 unsigned.
    assign magA = (is_signed && A[WIDTH-1]) ? -A : A;
    assign magB = (is_signed && B[WIDTH-1]) ? -B : B;

    // One restoring step. The 33-bit shifted remainder is compared against
    // the divisor; when it fits, the difference is below the divisor and so
    // the low 32 bits of the subtraction are exact.
    assign remShift = {rem_q, quo_q[WIDTH-1]};
    assign trialOk  = (remShift >= {1'b0, divisor_q});
    assign trial    = remShift[WIDTH-1:0] - divisor_q;
    assign remNext  = trialOk ? trial : remShift[WIDTH-1:0];
    assign quoNext  = {quo_q[WIDTH-2:0], trialOk};

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
            signA_q   <= 1'b0;
            signB_q   <= 1'b0;
            zero_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
            cnt_q     <= cnt_d;
            signA_q   <= signA_d;
            signB_q   <= signB_d;
            zero_q    <= zero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // Next-state and datapath control: latch operands in IDLE, iterate in
    // RUN, and always fall back to IDLE after the single DONE cycle.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;
        cnt_d     = cnt_q;
        signA_d   = signA_q;
        signB_d   = signB_q;
        zero_d    = zero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    signA_d   = is_signed & A[WIDTH-1];
                    signB_d   = is_signed & B[WIDTH-1];
                    divisor_d = magB;
                    quo_d     = magA;
                    rem_d     = '0;
                    cnt_d     = '0;
                    if (B == '0) begin
                        zero_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        zero_d  = 1'b0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                rem_d = remNext;
                quo_d = quoNext;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    lo_d    = (signA_q ^ signB_q) ? -quoNext : quoNext;
                    hi_d    = signA_q ? -remNext : remNext;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign HI       = hi_q;
    assign LO       = lo_q;
    assign busy     = (state_q == RUN) || (state_q == DONE);
    assign done     = (state_q == DONE);
    assign div_zero = (state_q == DONE) && zero_q;
    assign stateOut = (state_q == UNUSED) ? IDLE : state_q;

endmodule
